// File: rtl/median_filter_ctrl.sv
// median_filter_ctrl: row-buffering controller around an external median filter.
// MEDIAN_CTRL_EDGE_REPLICATE_EN selects last-row replication for the flush row (zeros otherwise).
module median_filter_ctrl #(
    parameter int COL   = 256,
    parameter int ROWS  = 256,
    parameter int WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic [3*WIDTH-1:0]     pix_in,
    input  logic                   pix_in_valid,
    output logic                   pix_in_ready,
    output logic [3*WIDTH-1:0]     pix_out,
    output logic                   pix_out_valid,
    input  logic                   pix_out_ready,
    output logic [COL*3*WIDTH-1:0] flt_row_in,
    output logic                   flt_set,
    input  logic [COL*3*WIDTH-1:0] flt_row_out,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int PW = 3*WIDTH;
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam int RW = $clog2(ROWS + 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COL - 1);
    localparam logic [RW-1:0] ALL_ROWS = RW'(ROWS);
`ifdef MEDIAN_CTRL_EDGE_REPLICATE_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, FILL, ISSUE, CAPT, DRAIN, FLUSH, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   col;
    logic [RW-1:0]   rows;
    logic            flush_done;
    logic [PW-1:0]   row_buf [COL];
    logic [PW-1:0]   out_buf [COL];
    logic [COL*PW-1:0] row_next, flush_row;
    logic            in_hs, out_hs, last_col;

    assign pix_in_ready  = state == FILL;
    assign pix_out_valid = state == DRAIN;
    assign busy          = state != IDLE;
    assign frame_done    = state == DONE;
    assign flt_set       = !(state == ISSUE && rows == '0);
    assign pix_out       = pix_out_valid ? out_buf[col] : '0;
    assign in_hs         = pix_in_valid && pix_in_ready;
    assign out_hs        = pix_out_valid && pix_out_ready;
    assign last_col      = col == LAST_COL;

    // The row handed to the filter must already contain the pixel accepted on this edge.
    always_comb begin
        row_next  = '0;
        flush_row = '0;
        for (int i = 0; i < COL; i++) begin
            row_next[(COL-1-i)*PW +: PW]  = (i == COL - 1) ? pix_in : row_buf[i];
            flush_row[(COL-1-i)*PW +: PW] = REPL ? row_buf[i] : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? FILL : IDLE;
            FILL:    state_nxt = (in_hs && last_col) ? ISSUE : FILL;
            ISSUE:   state_nxt = (rows == '0) ? FILL : CAPT;
            CAPT:    state_nxt = DRAIN;
            DRAIN:   state_nxt = !(out_hs && last_col) ? DRAIN :
                                 flush_done ? DONE : (rows == ALL_ROWS) ? FLUSH : FILL;
            FLUSH:   state_nxt = CAPT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            col        <= '0;
            rows       <= '0;
            flush_done <= 1'b0;
            flt_row_in <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                col        <= '0;
                rows       <= '0;
                flush_done <= 1'b0;
            end
            if (in_hs) begin
                row_buf[col] <= pix_in;
                col          <= last_col ? '0 : col + 1'b1;
                if (last_col) flt_row_in <= row_next;
            end
            if (state == ISSUE) rows <= rows + 1'b1;
            if (state == CAPT)
                for (int i = 0; i < COL; i++) out_buf[i] <= flt_row_out[(COL-1-i)*PW +: PW];
            if (out_hs) begin
                col <= last_col ? '0 : col + 1'b1;
                if (last_col && !flush_done && rows == ALL_ROWS) flt_row_in <= flush_row;
            end
            if (state == FLUSH) flush_done <= 1'b1;
        end
    end
endmodule
